// File: rtl/fifo_uart_tx.sv
// Drains a registered-read FIFO and serialises each popped byte as an 8N1
// UART frame (start bit, WIDTH data bits LSB first, one stop bit).
module fifo_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 104
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_enable,
  input  logic             i_empty,
  input  logic [WIDTH-1:0] i_datain,
  output logic             o_rden,
  output logic             o_tx,
  output logic             o_busy,
  output logic             o_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DONE_CLK = CW'(CLKS_PER_BIT - 2);
  localparam logic [IW-1:0] LAST_BIT = IW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} state_t;

  state_t           state;
  logic [CW-1:0]    clk_cnt;
  logic [IW-1:0]    bit_idx;
  logic [WIDTH-1:0] shreg;
  logic             bit_end;

  assign bit_end = (clk_cnt == LAST_CLK);

  // NOTE: every output is a register updated with <= in this one block, so
  // o_tx never glitches and each output is set one edge ahead of its state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      o_rden  <= 1'b0;
      o_tx    <= 1'b1;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      o_rden <= 1'b0;
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          o_tx <= 1'b1;
          if (i_enable && !i_empty) begin
            state  <= FETCH;
            o_rden <= 1'b1;
            o_busy <= 1'b1;
          end
        end
        FETCH: state <= LOAD;
        // The FIFO read port is registered: the popped byte is valid now.
        LOAD: begin
          shreg   <= i_datain;
          clk_cnt <= '0;
          bit_idx <= '0;
          o_tx    <= 1'b0;
          state   <= START;
        end
        START: begin
          if (bit_end) begin
            clk_cnt <= '0;
            o_tx    <= shreg[0];
            state   <= DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            shreg   <= shreg >> 1;
            if (bit_idx == LAST_BIT) begin
              o_tx  <= 1'b1;
              state <= STOP;
            end else begin
              o_tx    <= shreg[1];
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            clk_cnt <= '0;
            o_busy  <= 1'b0;
            state   <= IDLE;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
            o_done  <= (clk_cnt == DONE_CLK);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Randomised bench for fifo_uart_tx: a queue-based FIFO model with a
// registered read port, and a frame-timeline reference for every output.
module tb_fifo_uart_tx;

  localparam int WIDTH = 8;
  localparam int CPB   = 4;
  localparam int FRAME = (WIDTH + 2) * CPB;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             empty = 1'b1;
  logic [WIDTH-1:0] datain = '0;
  logic             rden, tx, busy, done;

  fifo_uart_tx #(.WIDTH(WIDTH), .CLKS_PER_BIT(CPB)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_enable(en),
    .i_empty (empty),
    .i_datain(datain),
    .o_rden  (rden),
    .o_tx    (tx),
    .o_busy  (busy),
    .o_done  (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // FIFO contents and reference-model state
  logic [WIDTH-1:0] q[$];
  int               cyc = 0;
  logic             m_act = 1'b0;
  int               m_k = 0;
  logic [WIDTH+1:0] m_frame = '0;
  logic             en_prev = 1'b0, emp_prev = 1'b1, rst_prev = 1'b1, tx_prev = 1'b1;
  logic             drive_next = 1'b0;
  logic [WIDTH-1:0] drive_val = '0;
  int               m_done_cnt = 0, dut_done_cnt = 0;
  int               rden_cyc[$];
  int               fall_cyc = -1, start_cyc = -1;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // FIFO read port: popped byte visible only in the cycle after o_rden.
  initial forever begin
    @(posedge clk);
    #1;
    if (drive_next) begin
      datain     = drive_val;
      drive_next = 1'b0;
    end else begin
      datain = WIDTH'($urandom);
    end
    empty = (q.size() == 0);
  end

  // Reference timeline: k=-2 read strobe, k=-1 load, k=0..FRAME-1 frame bits.
  initial forever begin
    logic exp_rden, exp_busy, exp_done, exp_tx;
    @(negedge clk);
    if (rst_prev) begin
      m_act = 1'b0;
    end else if (m_act) begin
      m_k++;
      if (m_k == FRAME) m_act = 1'b0;
    end else if (en_prev && !emp_prev) begin
      m_act      = 1'b1;
      m_k        = -2;
      m_frame    = {1'b1, q.pop_front(), 1'b0};
      drive_val  = m_frame[WIDTH:1];
      drive_next = 1'b1;
    end
    exp_rden = m_act && (m_k == -2);
    exp_busy = m_act;
    exp_done = m_act && (m_k == FRAME - 1);
    exp_tx   = (m_act && m_k >= 0) ? m_frame[m_k / CPB] : 1'b1;
    check("rden", 32'(rden), 32'(exp_rden));
    check("busy", 32'(busy), 32'(exp_busy));
    check("tx",   32'(tx),   32'(exp_tx));
    check("done", 32'(done), 32'(exp_done));
    if (exp_done) m_done_cnt++;
    if (done) dut_done_cnt++;
    if (rden) rden_cyc.push_back(cyc);
    if (emp_prev && !empty) fall_cyc = cyc;
    if (tx_prev && !tx && start_cyc < 0 && fall_cyc >= 0) start_cyc = cyc;
    en_prev  = en;
    emp_prev = empty;
    rst_prev = rst;
    tx_prev  = tx;
  end

  task automatic push(input logic [WIDTH-1:0] b);
    @(posedge clk);
    #2;
    q.push_back(b);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic wait_k(input int target, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (m_act && m_k == target) begin
        hit = 1'b1;
        break;
      end
    end
    check(tag, 32'(hit), 32'd1);
    #1;
  endtask

  initial begin
    wait_cycles(3);
    #1 rst = 1'b0;
    wait_cycles(3);

    // Single byte
    #1 en = 1'b1;
    push(8'hA5);
    wait_cycles(60);
    check("s1_done_count", 32'(dut_done_cnt), 32'd1);

    // Back-to-back
    rden_cyc.delete();
    push(8'h00);
    push(8'hFF);
    wait_cycles(110);
    check("s2_rden_count", 32'(rden_cyc.size()), 32'd2);
    if (rden_cyc.size() == 2)
      check("s2_rden_gap", 32'(rden_cyc[1] - rden_cyc[0]), 32'(FRAME + 3));

    // Empty FIFO for 100 cycles, then a push
    rden_cyc.delete();
    wait_cycles(100);
    check("s3_no_rden", 32'(rden_cyc.size()), 32'd0);
    fall_cyc  = -1;
    start_cyc = -1;
    push(8'h3C);
    wait_cycles(60);
    check("s3_started", 32'(start_cyc >= 0 && fall_cyc >= 0), 32'd1);
    check("s3_latency_ok", 32'(start_cyc - fall_cyc <= 3 && start_cyc > fall_cyc), 32'd1);

    // Enable drop during data bit 3
    push(8'h81);
    push(8'h99);
    wait_k(4 * CPB + 1, "s4_wait_bit3");
    en = 1'b0;
    rden_cyc.delete();
    wait_cycles(150);
    check("s4_no_rden", 32'(rden_cyc.size()), 32'd0);
    check("s4_pending", 32'(q.size()), 32'd1);
    check("s4_done_count", 32'(dut_done_cnt), 32'd5);
    @(posedge clk);
    #1 en = 1'b1;
    wait_cycles(60);

    // Reset during data bit 5
    push(8'h11);
    push(8'h22);
    wait_k(6 * CPB, "s5_wait_bit5");
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    wait_cycles(60);
    check("s5_queue_drained", 32'(q.size()), 32'd0);

    // Read latency with garbage around the valid cycle
    push(8'h5A);
    wait_cycles(60);

    // Random traffic with enable toggling
    for (int i = 0; i < 8; i++) begin
      push(WIDTH'($urandom));
      wait_cycles($urandom_range(0, 60));
      @(posedge clk);
      #1 en = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk);
    #1 en = 1'b1;
    wait_cycles(50 * (q.size() + 1) + 50);

    check("final_queue_empty", 32'(q.size()), 32'd0);
    check("final_done_count", 32'(dut_done_cnt), 32'(m_done_cnt));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
